multiply_sequencer: RTL and testbench



---
 rtl/multiply_sequencer_if.sv | 22 ++
 rtl/multiply_sequencer.sv | 91 +++++++++
 tb/tb_multiply_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/multiply_sequencer_if.sv
// Handshake and operand/product bundle between a requester and the
// shift-add multiply sequencer.
interface multiply_sequencer_if #(
    parameter int D_WIDTH = 34
);
    logic                   start_i;
    logic [D_WIDTH-1:0]     multiplicand_i;
    logic [D_WIDTH-1:0]     multiplier_i;
    logic                   busy_o;
    logic                   done_o;
    logic [2*D_WIDTH-1:0]   product_o;

    modport master (
        output start_i, multiplicand_i, multiplier_i,
        input  busy_o, done_o, product_o
    );

    modport slave (
        input  start_i, multiplicand_i, multiplier_i,
        output busy_o, done_o, product_o
    );
endinterface

// File: rtl/multiply_sequencer.sv
// Iterative unsigned shift-add multiplier: one iteration per clock for
// D_WIDTH clocks, then a one-cycle done pulse with the registered product.
module multiply_sequencer #(
    parameter int D_WIDTH = 34
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    multiply_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(D_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [D_WIDTH:0]       acc_q;
    logic [D_WIDTH-1:0]     mcand_q;
    logic [D_WIDTH-1:0]     mplier_q;
    logic [D_WIDTH-1:0]     lo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*D_WIDTH-1:0]   product_q;

    logic [D_WIDTH:0]       sum;
    logic [D_WIDTH:0]       acc_d;
    logic [D_WIDTH-1:0]     mplier_d;
    logic [D_WIDTH-1:0]     lo_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   last_iter;
    logic                   accept;

    // One shift-add step; the extra acc bit absorbs the carry of the add.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = sum >> 1;
        lo_d     = {sum[0], lo_q[D_WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
    end

    assign last_iter = (cnt_q == LAST_CNT);
    assign accept    = bus.start_i && ((state_q == IDLE) || (state_q == DONE));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand_q  <= bus.multiplicand_i;
                        mplier_q <= bus.multiplier_i;
                        acc_q    <= '0;
                        lo_q     <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    lo_q     <= lo_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    // Product is latched from the final iteration's results and held until the next one.
                    if (last_iter) begin
                        product_q <= {acc_d[D_WIDTH-1:0], lo_d};
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o    = (state_q == RUN);
    assign bus.done_o    = (state_q == DONE);
    assign bus.product_o = product_q;
endmodule

// File: tb/tb_multiply_sequencer.sv
// Self-checking bench: stimulus tables per window, a timeline/arithmetic
// reference model, and per-cycle comparison of busy, done and product.
module tb_multiply_sequencer;
    localparam int DW  = 34;
    localparam int LAT = DW + 1;
    localparam int WIN = 200;

    typedef logic [DW-1:0]   op_t;
    typedef logic [2*DW-1:0] prod_t;

    logic clk;
    logic rst_n;

    multiply_sequencer_if #(.D_WIDTH(DW)) bus ();

    multiply_sequencer #(.D_WIDTH(DW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks;
    int    n_errors;
    prod_t last_prod;

    bit    st_tab [WIN];
    op_t   a_tab  [WIN];
    op_t   b_tab  [WIN];
    bit    exp_busy [WIN];
    bit    exp_done [WIN];
    prod_t exp_prod [WIN];

    localparam op_t ALL1 = {DW{1'b1}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < WIN; i++) begin
            st_tab[i] = 1'b0;
            a_tab[i]  = '0;
            b_tab[i]  = '0;
        end
    endtask

    task automatic set_start(input int c, input op_t a, input op_t b);
        st_tab[c] = 1'b1;
        a_tab[c]  = a;
        b_tab[c]  = b;
    endtask

    function automatic op_t rnd_op();
        logic [63:0] r;
        int sel;
        r   = {$urandom(), $urandom()};
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return '0;
            1:       return ALL1;
            2:       return op_t'(1);
            default: return r[DW-1:0];
        endcase
    endfunction

    // Timeline model: a start seen while free begins an operation; busy for
    // the next DW cycles, done (with A*B) on the one after, free again then.
    task automatic build_expected(input int ncyc);
        bit    done_at [WIN + LAT];
        prod_t val     [WIN + LAT];
        int    free_at;
        prod_t cur;
        for (int i = 0; i < WIN + LAT; i++) begin
            done_at[i] = 1'b0;
            val[i]     = '0;
        end
        for (int i = 0; i < WIN; i++) exp_busy[i] = 1'b0;
        free_at = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (st_tab[c] && c >= free_at) begin
                for (int k = 1; k <= DW; k++)
                    if (c + k < WIN) exp_busy[c + k] = 1'b1;
                done_at[c + LAT] = 1'b1;
                val[c + LAT]     = prod_t'(a_tab[c]) * prod_t'(b_tab[c]);
                free_at          = c + LAT;
            end
        end
        cur = last_prod;
        for (int c = 0; c < WIN; c++) begin
            if (done_at[c]) cur = val[c];
            exp_done[c] = done_at[c];
            exp_prod[c] = cur;
        end
    endtask

    // Entered at a falling edge; window cycle c samples, then drives table row c.
    task automatic run_window(input int ncyc, input string name);
        build_expected(ncyc);
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("%s busy c%0d", name, c), bus.busy_o, exp_busy[c]);
            check($sformatf("%s done c%0d", name, c), bus.done_o, exp_done[c]);
            check($sformatf("%s prod c%0d", name, c), bus.product_o, exp_prod[c]);
            bus.start_i        = st_tab[c];
            bus.multiplicand_i = a_tab[c];
            bus.multiplier_i   = b_tab[c];
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        last_prod   = exp_prod[ncyc - 1];
    endtask

    initial begin
        int dcount;
        int bcount;
        n_checks = 0;
        n_errors = 0;
        last_prod = '0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.multiplicand_i = '0;
        bus.multiplier_i = '0;

        repeat (3) @(negedge clk);
        check("reset busy", bus.busy_o, 1'b0);
        check("reset done", bus.done_o, 1'b0);
        check("reset prod", bus.product_o, '0);
        rst_n = 1'b1;
        @(negedge clk);

        clear_tab();
        set_start(0, op_t'(3), op_t'(5));
        run_window(60, "a3b5");
        check("a3b5 product", last_prod, 15);

        clear_tab();
        set_start(0, ALL1, ALL1);
        run_window(60, "max");
        check("max product", last_prod, {{(DW-1){1'b1}}, 1'b0, {(DW-1){1'b0}}, 1'b1});

        clear_tab();
        set_start(0, op_t'(0), ALL1);
        set_start(40, ALL1, op_t'(1));
        run_window(100, "zero_one");

        clear_tab();
        set_start(0, op_t'(7), op_t'(9));
        set_start(10, op_t'(2), op_t'(2));
        run_window(100, "drop");
        check("drop product", last_prod, 63);

        clear_tab();
        for (int c = 0; c <= LAT; c++)
            set_start(c, (c == 0) ? op_t'(6) : op_t'(10), (c == 0) ? op_t'(7) : op_t'(11));
        run_window(90, "b2b");
        check("b2b product", last_prod, 110);

        // Asynchronous reset in the middle of RUN cycle 20.
        bus.start_i = 1'b1;
        bus.multiplicand_i = op_t'(4);
        bus.multiplier_i = op_t'(4);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        check("rst pre busy", bus.busy_o, 1'b1);
        check("rst pre prod", bus.product_o, last_prod);
        #2 rst_n = 1'b0;
        #1;
        check("rst async busy", bus.busy_o, 1'b0);
        check("rst async done", bus.done_o, 1'b0);
        check("rst async prod", bus.product_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        bcount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done_o) dcount++;
            if (bus.busy_o) bcount++;
        end
        check("post rst done count", dcount, 0);
        check("post rst busy count", bcount, 0);
        last_prod = '0;

        for (int t = 0; t < 8; t++) begin
            clear_tab();
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_start(c, rnd_op(), rnd_op());
                end else begin
                    a_tab[c] = rnd_op();
                    b_tab[c] = rnd_op();
                end
            end
            run_window(WIN, $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
